// File: rtl/word_arbiter.sv
// Two-requester arbiter in front of a single Q-without-U word checker.
// One requester at a time owns the checker for a whole word. Its bytes are
// forwarded one cycle late on chk_byte. The checker's verdict is captured in
// the cycle where the terminating zero byte is on chk_byte. A word longer than
// MAX_WORD is cut short with a forced zero, and the rest of that word is
// discarded.
//
// Ports
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   req_valid[1:0]           : per-requester byte valid
//   req_byte0, req_byte1     : per-requester byte, 8'd0 ends a word
//   req_ready[1:0]           : per-requester accept (valid & ready transfers)
//   chk_byte                 : registered byte stream to the checker
//   chk_result               : checker verdict, meaningful while chk_byte == 0
//   grant[1:0]               : one-hot current owner, 2'b00 when idle
//   res_valid[1:0]           : one-cycle result pulse for the owning requester
//   res_match, res_overflow  : result qualifiers, only meaningful with res_valid
//   match_count              : saturating count of matched words
module word_arbiter #(
  parameter logic [7:0]  IDLE_BYTE = 8'd32,
  parameter int unsigned MAX_WORD  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_byte0,
  input  logic [7:0]  req_byte1,
  output logic [1:0]  req_ready,
  output logic [7:0]  chk_byte,
  input  logic        chk_result,
  output logic [1:0]  grant,
  output logic [1:0]  res_valid,
  output logic        res_match,
  output logic        res_overflow,
  output logic [15:0] match_count
);

  localparam logic [7:0] MaxCnt = 8'(MAX_WORD);

  typedef enum logic [1:0] {StIdle, StStream, StTerm, StDrain} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        ptr_q, ptr_d;              // requester served last
  logic [7:0]  chk_byte_q, chk_byte_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cap_q, cap_d;              // chk_byte_q is a terminator: sample chk_result
  logic        cap_ovf_q, cap_ovf_d;
  logic [1:0]  cap_owner_q, cap_owner_d;
  logic [1:0]  res_valid_q, res_valid_d;
  logic        res_match_q, res_match_d;
  logic        res_overflow_q, res_overflow_d;
  logic [15:0] match_count_q, match_count_d;

  logic       own_valid;
  logic [7:0] own_byte;
  logic       own_zero;
  logic       force_term;
  logic       accept;

  assign own_valid  = |(req_valid & grant_q);
  assign own_byte   = grant_q[1] ? req_byte1 : req_byte0;
  assign own_zero   = (own_byte == 8'd0);
  // Word already at its limit and the owner offers yet another non-zero byte.
  assign force_term = (state_q == StStream) && (cnt_q == MaxCnt) && own_valid && !own_zero;

  always_comb begin
    req_ready = 2'b00;
    if ((state_q == StStream && !force_term) || state_q == StDrain) begin
      req_ready = grant_q;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    ptr_d          = ptr_q;
    chk_byte_d     = IDLE_BYTE;
    cnt_d          = cnt_q;
    cap_d          = 1'b0;
    cap_ovf_d      = cap_ovf_q;
    cap_owner_d    = cap_owner_q;
    res_valid_d    = 2'b00;
    res_match_d    = 1'b0;
    res_overflow_d = 1'b0;
    match_count_d  = match_count_q;

    if (cap_q) begin
      res_valid_d    = cap_owner_q;
      res_match_d    = chk_result;
      res_overflow_d = cap_ovf_q;
      if (chk_result && match_count_q != 16'hFFFF) begin
        match_count_d = match_count_q + 16'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        grant_d = 2'b00;
        if (req_valid != 2'b00) begin
          state_d = StStream;
          cnt_d   = 8'd0;
          if (req_valid == 2'b11) begin
            grant_d = ptr_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = req_valid;
          end
        end
      end
      StStream: begin
        if (force_term) begin
          state_d = StTerm;
        end else if (accept) begin
          chk_byte_d = own_byte;
          if (own_zero) begin
            state_d     = StIdle;
            grant_d     = 2'b00;
            ptr_d       = grant_q[1];
            cap_d       = 1'b1;
            cap_ovf_d   = 1'b0;
            cap_owner_d = grant_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StTerm: begin
        chk_byte_d  = 8'd0;
        state_d     = StDrain;
        cap_d       = 1'b1;
        cap_ovf_d   = 1'b1;
        cap_owner_d = grant_q;
      end
      StDrain: begin
        if (accept && own_zero) begin
          state_d = StIdle;
          grant_d = 2'b00;
          ptr_d   = grant_q[1];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      grant_q        <= 2'b00;
      ptr_q          <= 1'b1;
      chk_byte_q     <= 8'd0;
      cnt_q          <= 8'd0;
      cap_q          <= 1'b0;
      cap_ovf_q      <= 1'b0;
      cap_owner_q    <= 2'b00;
      res_valid_q    <= 2'b00;
      res_match_q    <= 1'b0;
      res_overflow_q <= 1'b0;
      match_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      ptr_q          <= ptr_d;
      chk_byte_q     <= chk_byte_d;
      cnt_q          <= cnt_d;
      cap_q          <= cap_d;
      cap_ovf_q      <= cap_ovf_d;
      cap_owner_q    <= cap_owner_d;
      res_valid_q    <= res_valid_d;
      res_match_q    <= res_match_d;
      res_overflow_q <= res_overflow_d;
      match_count_q  <= match_count_d;
    end
  end

  assign grant        = grant_q;
  assign chk_byte     = chk_byte_q;
  assign res_valid    = res_valid_q;
  assign res_match    = res_match_q;
  assign res_overflow = res_overflow_q;
  assign match_count  = match_count_q;

endmodule

// File: tb/tb_word_arbiter.sv
// Bench for word_arbiter: directed words plus random traffic. Expected results
// come from word contents (Q not followed by U among the forwarded bytes) and a
// word-level round-robin order model.
module tb_word_arbiter;

  localparam logic [7:0] IDLE = 8'd32;
  localparam int         MAXW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [7:0]  req_byte0 = 8'd0;
  logic [7:0]  req_byte1 = 8'd0;
  logic [1:0]  req_ready;
  logic [7:0]  chk_byte;
  logic        chk_result;
  logic [1:0]  grant;
  logic [1:0]  res_valid;
  logic        res_match;
  logic        res_overflow;
  logic [15:0] match_count;

  always #5 clock = ~clock;

  word_arbiter #(
    .IDLE_BYTE(IDLE),
    .MAX_WORD (MAXW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_byte0   (req_byte0),
    .req_byte1   (req_byte1),
    .req_ready   (req_ready),
    .chk_byte    (chk_byte),
    .chk_result  (chk_result),
    .grant       (grant),
    .res_valid   (res_valid),
    .res_match   (res_match),
    .res_overflow(res_overflow),
    .match_count (match_count)
  );

  // Checker: ignores idle bytes, flags a Q not followed by U, clears on zero.
  logic chk_pend = 1'b0;
  logic chk_hit  = 1'b0;
  always @(posedge clock) begin
    if (chk_byte == 8'd0) begin
      chk_pend <= 1'b0;
      chk_hit  <= 1'b0;
    end else if (chk_byte != IDLE) begin
      if (chk_pend && chk_byte != "U") chk_hit <= 1'b1;
      chk_pend <= (chk_byte == "Q");
    end
  end
  assign chk_result = (chk_byte == 8'd0) && (chk_hit || chk_pend);

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] tx0[$];
  logic [7:0] tx1[$];
  logic [1:0] ex0[$];     // {match, overflow} per word, in order
  logic [1:0] ex1[$];
  int         order_q[$];
  int         nw[2];
  int         last_model = 1;
  int         mc = 0;
  int         pos[2];
  int         term_cyc[2];
  logic [7:0] w[$];
  logic [7:0] alpha[4];
  bit         got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_word(input int r, input logic [7:0] wd[$]);
    int   n   = wd.size();
    int   fwd = (n > MAXW) ? MAXW : n;
    logic m   = 1'b0;
    for (int j = 0; j < fwd; j++) begin
      if (wd[j] == "Q" && (j == fwd - 1 || wd[j+1] != "U")) m = 1'b1;
    end
    wd.push_back(8'd0);
    if (r == 0) begin
      tx0 = {tx0, wd};
      ex0.push_back({m, n > MAXW});
    end else begin
      tx1 = {tx1, wd};
      ex1.push_back({m, n > MAXW});
    end
    nw[r]++;
  endtask

  task automatic add_str(input int r, input string s);
    logic [7:0] wd[$];
    for (int i = 0; i < s.len(); i++) wd.push_back(s[i]);
    add_word(r, wd);
  endtask

  task automatic build_order();
    int a = nw[0];
    int b = nw[1];
    int p;
    while (a + b > 0) begin
      if (a > 0 && b > 0) p = 1 - last_model;
      else p = (a > 0) ? 0 : 1;
      order_q.push_back(p);
      if (p == 0) a--; else b--;
      last_model = p;
    end
    nw[0] = 0;
    nw[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_chk_byte", 32'(chk_byte), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_match", 32'(res_match), 32'(0));
    check("rst_res_overflow", 32'(res_overflow), 32'(0));
    check("rst_match_count", 32'(match_count), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    mc = 0;
    last_model = 1;
    pos[0] = 0;
    pos[1] = 0;
  endtask

  task automatic run(input int budget);
    int         cyc = 0;
    int         i;
    logic [1:0] acc;
    logic [1:0] v;
    logic [1:0] prev_g;
    logic [7:0] b;
    logic [7:0] eb;
    logic [1:0] e;
    bit         done;
    build_order();
    prev_g = grant;
    while ((tx0.size() + tx1.size() + ex0.size() + ex1.size() > 0) && cyc < budget) begin
      @(negedge clock);
      // Bubbles only inside a word so the word-level arbitration order holds.
      v[0] = (tx0.size() > 0) && (pos[0] == 0 || $urandom_range(3) != 0);
      v[1] = (tx1.size() > 0) && (pos[1] == 0 || $urandom_range(3) != 0);
      req_valid = v;
      req_byte0 = (tx0.size() > 0) ? tx0[0] : 8'hEE;
      req_byte1 = (tx1.size() > 0) ? tx1[0] : 8'hEE;
      #1;
      acc = req_valid & req_ready;
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));
      @(posedge clock);
      #1;
      cyc++;
      if (grant != 2'b00 && prev_g == 2'b00) begin
        check("grant_onehot", 32'($countones(grant) == 1), 32'(1));
        if (order_q.size() == 0) begin
          check("grant_extra", 32'(grant), 32'(0));
        end else begin
          i = order_q.pop_front();
          check("grant_order", 32'(grant), 32'(1) << i);
        end
      end
      prev_g = grant;
      if (acc != 2'b00) begin
        i  = acc[1] ? 1 : 0;
        b  = (i == 0) ? tx0.pop_front() : tx1.pop_front();
        eb = (pos[i] < MAXW || (pos[i] == MAXW && b == 8'd0)) ? b : IDLE;
        check("chk_byte", 32'(chk_byte), 32'(eb));
        if (b == 8'd0) begin
          if (pos[i] <= MAXW) term_cyc[i] = cyc;
          pos[i] = 0;
        end else begin
          pos[i]++;
        end
      end
      if (res_valid != 2'b00) begin
        check("res_onehot", 32'($countones(res_valid) == 1), 32'(1));
        i = res_valid[1] ? 1 : 0;
        if (((i == 0) ? ex0.size() : ex1.size()) == 0) begin
          check("res_extra", 32'(res_valid), 32'(0));
        end else begin
          e = (i == 0) ? ex0.pop_front() : ex1.pop_front();
          check("res_match", 32'(res_match), 32'(e[1]));
          check("res_overflow", 32'(res_overflow), 32'(e[0]));
          if (!e[0]) check("res_latency", 32'(cyc - term_cyc[i]), 32'(1));
          if (e[1] && mc < 65535) mc++;
          check("match_count", 32'(match_count), 32'(mc));
        end
      end
    end
    done = (tx0.size() + tx1.size() + ex0.size() + ex1.size() == 0);
    check("run_done", 32'(done), 32'(1));
    check("order_done", 32'(order_q.size()), 32'(0));
    @(negedge clock);
    req_valid = 2'b00;
  endtask

  initial begin
    alpha[0] = "Q";
    alpha[1] = "U";
    alpha[2] = "A";
    alpha[3] = "B";
    do_reset();

    add_str(0, "QA");
    run(100);
    check("mc_qa", 32'(match_count), 32'(1));

    add_str(1, "QU");
    run(100);
    check("mc_qu", 32'(match_count), 32'(1));

    do_reset();
    add_str(0, "Q");
    add_str(0, "Q");
    add_str(1, "Q");
    add_str(1, "Q");
    run(200);
    check("mc_rr", 32'(match_count), 32'(4));

    add_str(0, "QQQQQQ");
    run(100);
    add_str(1, "QAQU");
    run(100);
    add_str(0, "");
    run(100);
    check("mc_dir", 32'(match_count), 32'(6));

    // Reset in the middle of a word: no result, requester starts over.
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      @(negedge clock);
      req_valid = 2'b01;
      req_byte0 = "Q";
      #1;
      got = req_ready[0];
      @(posedge clock);
    end
    check("mid_accept", 32'(got), 32'(1));
    #1;
    check("mid_chk_byte", 32'(chk_byte), 32'("Q"));
    @(negedge clock);
    reset = 1'b1;
    req_valid = 2'b00;
    @(posedge clock);
    #1;
    check("mid_rst_grant", 32'(grant), 32'(0));
    check("mid_rst_chk", 32'(chk_byte), 32'(0));
    check("mid_rst_resv", 32'(res_valid), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    mc = 0;
    last_model = 1;
    pos[0] = 0;
    pos[1] = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("mid_no_result", 32'(res_valid), 32'(0));
    end
    add_str(0, "A");
    run(100);

    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < 2; r++) begin
        for (int k = 0; k < 8; k++) begin
          w.delete();
          for (int j = 0; j < int'($urandom_range(7, 0)); j++) begin
            w.push_back(alpha[$urandom_range(3, 0)]);
          end
          add_word(r, w);
        end
      end
      run(3000);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/word_arbiter.md
WORD_ARBITER -- requirements
Module: word_arbiter

Interface
REQ-001 Parameter: IDLE_BYTE, default 8'd32, byte driven to the checker when no byte is forwarded.
REQ-002 Parameter: MAX_WORD, default 64, maximum non-zero bytes per word before forced termination (range 1..255).
REQ-003 clock  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester byte valid; bit i for requester i.
REQ-006 req_byte0, req_byte1  input  8 each  requester byte; 8'd0 terminates a word.
REQ-007 req_ready  output  2  per-requester accept; a byte transfers when valid & ready on the same edge.
REQ-008 chk_byte  output  8  registered byte stream to the Q-without-U word checker.
REQ-009 chk_result  input  1  checker combinational result, valid in the cycle chk_byte == 0.
REQ-010 grant  output  2  one-hot owner of the checker, 2'b00 when none.
REQ-011 res_valid  output  2  one-cycle pulse per requester when its word result is ready.
REQ-012 res_match, res_overflow  output  1 each  result qualifiers, valid only with res_valid.
REQ-013 match_count  output  16  total matched words, saturating at 16'hFFFF.

Function
REQ-014 States SHALL be IDLE, STREAM, TERM, DRAIN.
REQ-015 IDLE: grant 00, req_ready 00, chk_byte <= IDLE_BYTE each cycle.
REQ-016 IDLE arbitration: one requester valid -> grant it; both valid -> grant the one not served last (round-robin pointer); none -> stay IDLE.
REQ-017 Grant SHALL be registered; IDLE -> STREAM takes one cycle; grant held until the word ends.
REQ-018 STREAM: req_ready = grant; other requester's ready SHALL be 0.
REQ-019 Accepted byte at edge N SHALL appear on chk_byte in cycle N+1; with no accepted byte chk_byte <= IDLE_BYTE.
REQ-020 Byte counter SHALL count accepted non-zero bytes of the current word; cleared on entering STREAM.
REQ-021 Accepted 8'd0 in STREAM -> IDLE; round-robin pointer <= granted requester.
REQ-022 Result capture: in the cycle chk_byte == 0 due to a terminator, chk_result SHALL be registered; res_valid[owner], res_match = chk_result asserted the following cycle (terminator accepted at N -> res_valid in N+2).
REQ-023 res_match = 1 SHALL increment match_count by 1, saturating.
REQ-024 Byte counter == MAX_WORD in STREAM and next byte non-zero: req_ready SHALL be 0, state -> TERM.
REQ-025 TERM (one cycle): chk_byte <= 8'd0; result captured per REQ-022 with res_overflow = 1; -> DRAIN.
REQ-026 DRAIN: req_ready = grant; accepted bytes discarded (chk_byte <= IDLE_BYTE); accepted 8'd0 -> IDLE, updates pointer, produces no second result.
REQ-027 Byte counter == MAX_WORD and next byte is 8'd0: normal termination, res_overflow = 0.
REQ-028 Empty word (first byte 8'd0) SHALL produce a result with res_match = chk_result (0 from a cleared checker).
REQ-029 Non-owner req_valid SHALL be held pending with no effect until IDLE arbitration.
REQ-030 res_valid SHALL be at most one-hot and never overlap for two results.

Reset
REQ-031 Reset: state IDLE, grant 00, req_ready 00, chk_byte 8'd0 (clears checker flags), res_valid 00, res_match 0, res_overflow 0, match_count 0, pointer = requester 1 (requester 0 wins first tie).
REQ-032 Reset mid-word SHALL abandon the word with no result pulse; the interrupted requester SHALL restart with a new word.

Verification
REQ-033 Req0 sends "Q","A",0 -> chk_byte 81,65,0 on consecutive cycles; res_valid=01, res_match=1 two cycles after 0 accepted; match_count=1.
REQ-034 Req1 sends "Q","U",0 -> res_valid=10, res_match=0, match_count unchanged.
REQ-035 Both valid from reset, each sending "Q",0 twice -> grant order 01,10,01,10; four results, match_count=4.
REQ-036 MAX_WORD=4, req0 sends 6 x "Q" then 0 -> 4 bytes forwarded, chk_byte 0 in TERM, res_overflow=1, res_match=1; remaining 2 bytes and 0 drained; single result.
REQ-037 Reset asserted after req0 "Q" accepted mid-word -> no res_valid, chk_byte=0, grant=00; subsequent "A",0 from req0 -> res_match=0.
REQ-038 Req0 sends 0 immediately -> res_valid=01, res_match=0, res_overflow=0.
